// File: rtl/watch_pkg.sv
// Shared time record, limits and time arithmetic for the countdown timers.
package watch_pkg;

    localparam int MAX_HOURS = 23;
    localparam int MAX_MINS  = 59;
    localparam int MAX_SECS  = 59;

    localparam int HOURS_W = 5;
    localparam int MINS_W  = 6;
    localparam int SECS_W  = 6;

    typedef struct packed {
        logic [HOURS_W-1:0] hours;
        logic [MINS_W-1:0]  mins;
        logic [SECS_W-1:0]  secs;
    } time_t;

    localparam time_t TIME_ZERO = '0;
    localparam time_t TIME_ONE  = '{hours: '0, mins: '0, secs: SECS_W'(1)};
    localparam time_t TIME_MAX  = '{hours: HOURS_W'(MAX_HOURS),
                                    mins:  MINS_W'(MAX_MINS),
                                    secs:  SECS_W'(MAX_SECS)};

    // One-second decrement with borrow; caller guarantees t is nonzero.
    function automatic time_t dec_time(input time_t t);
        time_t r;
        r = t;
        if (t.secs != '0) begin
            r.secs = t.secs - 1'b1;
        end else begin
            r.secs = SECS_W'(MAX_SECS);
            if (t.mins != '0) begin
                r.mins = t.mins - 1'b1;
            end else begin
                r.mins  = MINS_W'(MAX_MINS);
                r.hours = t.hours - 1'b1;
            end
        end
        return r;
    endfunction

    // Add a constant number of seconds with carry, saturating at 23:59:59.
    // step is a parameter at every call site, so the divides fold away.
    function automatic time_t add_secs(input time_t t, input int step);
        int s;
        int m;
        int h;
        s = int'(t.secs)  + (step % 60);
        m = int'(t.mins)  + ((step / 60) % 60);
        h = int'(t.hours) + (step / 3600);
        if (s > MAX_SECS) begin
            s = s - 60;
            m = m + 1;
        end
        if (m > MAX_MINS) begin
            m = m - 60;
            h = h + 1;
        end
        if (h > MAX_HOURS) return TIME_MAX;
        return '{hours: HOURS_W'(h), mins: MINS_W'(m), secs: SECS_W'(s)};
    endfunction

endpackage

// File: rtl/countdown_channel.sv
// One timer channel: stored time, run flag, alarm flag and alarm duration counter.
// Action strobes arrive already prioritised (at most one of clear/toggle/plus).
module countdown_channel
    import watch_pkg::*;
#(
    parameter int STEP_SECS   = 60,
    parameter int ALARM_TICKS = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               do_clear,
    input  logic               do_toggle,
    input  logic               do_plus,
    output logic [HOURS_W-1:0] hours,
    output logic [MINS_W-1:0]  mins,
    output logic [SECS_W-1:0]  secs,
    output logic               running,
    output logic               alarm
);

    localparam int AC_W = $clog2(ALARM_TICKS + 1);

    time_t           t;
    logic [AC_W-1:0] acnt;
    logic            is_zero;
    logic            is_one;

    assign is_zero = (t == TIME_ZERO);
    assign is_one  = (t == TIME_ONE);

    // Channel state update: clear beats toggle beats plus; a toggle cycle never decrements.
    always_ff @(posedge clk) begin
        if (reset || do_clear) begin
            t       <= TIME_ZERO;
            running <= 1'b0;
            alarm   <= 1'b0;
            acnt    <= '0;
        end else if (do_toggle) begin
            if (alarm) begin
                alarm   <= 1'b0;
                running <= 1'b0;
                acnt    <= '0;
            end else if (!is_zero) begin
                running <= !running;
            end
        end else begin
            if (do_plus && !running) begin
                t <= add_secs(t, STEP_SECS);
            end else if (tick && running && !is_zero) begin
                t <= dec_time(t);
                if (is_one) begin
                    running <= 1'b0;
                    alarm   <= 1'b1;
                    acnt    <= '0;
                end
            end
            // Alarm is never set while running, so this cannot collide with the set above.
            if (tick && alarm) begin
                if (acnt == AC_W'(ALARM_TICKS - 1)) begin
                    alarm <= 1'b0;
                    acnt  <= '0;
                end else begin
                    acnt <= acnt + 1'b1;
                end
            end
        end
    end

    assign hours = t.hours;
    assign mins  = t.mins;
    assign secs  = t.secs;

endmodule

// File: rtl/multi_countdown_timer.sv
// Multi-channel countdown timer: prescaler, input edge detection, channel
// selection and display mux; per-channel state lives in countdown_channel.
module multi_countdown_timer
    import watch_pkg::*;
#(
    parameter int CLK_FREQ    = 50000000,
    parameter int TICK_HZ     = 1,
    parameter int CHANNELS    = 4,
    parameter int STEP_SECS   = 60,
    parameter int ALARM_TICKS = 10,
    localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sel,
    input  logic                start_stop,
    input  logic                plus,
    input  logic                clear,
    output logic [SEL_W-1:0]    sel_idx,
    output logic [4:0]          disp_hours,
    output logic [5:0]          disp_mins,
    output logic [5:0]          disp_secs,
    output logic [CHANNELS-1:0] running,
    output logic [CHANNELS-1:0] alarm
);

    localparam int DIV   = CLK_FREQ / TICK_HZ;
    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] presc;
    logic             tick;
    logic [3:0]       in_vec;
    logic [3:0]       prev;
    logic             armed;
    logic [3:0]       edges;
    logic             sel_e, ss_e, plus_e, clr_e;

    logic [CHANNELS-1:0]              do_clear, do_toggle, do_plus;
    logic [CHANNELS-1:0][HOURS_W-1:0] ch_hours;
    logic [CHANNELS-1:0][MINS_W-1:0]  ch_mins;
    logic [CHANNELS-1:0][SECS_W-1:0]  ch_secs;

    assign tick = (presc == CNT_W'(DIV - 1));

    // Free-running prescaler; tick is the last count before wrap.
    always_ff @(posedge clk) begin
        if (reset || tick) presc <= '0;
        else               presc <= presc + 1'b1;
    end

    assign in_vec = {sel, start_stop, plus, clear};

    // Previous-level registers; armed masks the first cycle after reset so a
    // level held high through release is not seen as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev  <= '0;
            armed <= 1'b0;
        end else begin
            prev  <= in_vec;
            armed <= 1'b1;
        end
    end

    assign edges = in_vec & ~prev & {4{armed}};
    assign {sel_e, ss_e, plus_e, clr_e} = edges;

    // Selection advance with wrap; coincident actions use the old index.
    always_ff @(posedge clk) begin
        if (reset)
            sel_idx <= '0;
        else if (sel_e)
            sel_idx <= (sel_idx == SEL_W'(CHANNELS - 1)) ? '0 : sel_idx + 1'b1;
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic hit;
        assign hit          = (sel_idx == SEL_W'(g));
        assign do_clear[g]  = hit & clr_e;
        assign do_toggle[g] = hit & ss_e & ~clr_e;
        assign do_plus[g]   = hit & plus_e & ~ss_e & ~clr_e;

        countdown_channel #(
            .STEP_SECS  (STEP_SECS),
            .ALARM_TICKS(ALARM_TICKS)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .tick     (tick),
            .do_clear (do_clear[g]),
            .do_toggle(do_toggle[g]),
            .do_plus  (do_plus[g]),
            .hours    (ch_hours[g]),
            .mins     (ch_mins[g]),
            .secs     (ch_secs[g]),
            .running  (running[g]),
            .alarm    (alarm[g])
        );
    end

    // Display mux from the selected channel's registered time.
    always_comb begin
        disp_hours = '0;
        disp_mins  = '0;
        disp_secs  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_idx == SEL_W'(i)) begin
                disp_hours = ch_hours[i];
                disp_mins  = ch_mins[i];
                disp_secs  = ch_secs[i];
            end
        end
    end

endmodule

// File: tb/tb_multi_countdown_timer.sv
// Bench for multi_countdown_timer: directed scenarios plus random input
// traffic, checked every cycle against a seconds-based reference model.
module tb_multi_countdown_timer;

    localparam int DIV  = 10;
    localparam int CH   = 4;
    localparam int STEP = 60;
    localparam int AT   = 3;
    localparam int TMAX = 86399;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sel = 1'b0, start_stop = 1'b0, plus = 1'b0, clear = 1'b0;
    logic [1:0] sel_idx;
    logic [4:0] disp_hours;
    logic [5:0] disp_mins, disp_secs;
    logic [3:0] running, alarm;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each channel's time kept as total seconds.
    int m_t[CH];
    bit m_run[CH];
    bit m_alm[CH];
    int m_ac[CH];
    int m_cnt = 0, m_sel = 0, m_ticks = 0;
    bit p_sel = 0, p_ss = 0, p_pl = 0, p_clr = 0, m_first = 1;

    multi_countdown_timer #(
        .CLK_FREQ(10), .TICK_HZ(1), .CHANNELS(CH), .STEP_SECS(STEP), .ALARM_TICKS(AT)
    ) dut (
        .clk(clk), .reset(reset), .sel(sel), .start_stop(start_stop), .plus(plus),
        .clear(clear), .sel_idx(sel_idx), .disp_hours(disp_hours), .disp_mins(disp_mins),
        .disp_secs(disp_secs), .running(running), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit tk, e_sel, e_ss, e_pl, e_clr;
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                m_t[c] = 0; m_run[c] = 0; m_alm[c] = 0; m_ac[c] = 0;
            end
            m_cnt = 0; m_sel = 0; m_first = 1;
            p_sel = 0; p_ss = 0; p_pl = 0; p_clr = 0;
        end else begin
            tk    = (m_cnt == DIV - 1);
            m_cnt = tk ? 0 : m_cnt + 1;
            if (tk) m_ticks++;
            e_sel = sel && !p_sel && !m_first;
            e_ss  = start_stop && !p_ss && !m_first;
            e_pl  = plus && !p_pl && !m_first;
            e_clr = clear && !p_clr && !m_first;
            p_sel = sel; p_ss = start_stop; p_pl = plus; p_clr = clear; m_first = 0;
            for (int c = 0; c < CH; c++) begin
                if (c == m_sel && e_clr) begin
                    m_t[c] = 0; m_run[c] = 0; m_alm[c] = 0; m_ac[c] = 0;
                end else if (c == m_sel && e_ss) begin
                    if (m_alm[c]) begin
                        m_alm[c] = 0; m_run[c] = 0;
                    end else if (m_t[c] != 0) begin
                        m_run[c] = !m_run[c];
                    end
                end else begin
                    if (c == m_sel && e_pl && !m_run[c])
                        m_t[c] = (m_t[c] + STEP > TMAX) ? TMAX : m_t[c] + STEP;
                    if (tk) begin
                        if (m_alm[c]) begin
                            m_ac[c]++;
                            if (m_ac[c] == AT) m_alm[c] = 0;
                        end
                        if (m_run[c] && m_t[c] > 0) begin
                            m_t[c]--;
                            if (m_t[c] == 0) begin
                                m_run[c] = 0; m_alm[c] = 1; m_ac[c] = 0;
                            end
                        end
                    end
                end
            end
            if (e_sel) m_sel = (m_sel + 1) % CH;
        end
    endtask

    task automatic check_all();
        logic [3:0] rv, av;
        for (int c = 0; c < CH; c++) begin
            rv[c] = m_run[c];
            av[c] = m_alm[c];
        end
        chk("sel_idx", sel_idx, m_sel);
        chk("disp_hours", disp_hours, m_t[m_sel] / 3600);
        chk("disp_mins", disp_mins, (m_t[m_sel] / 60) % 60);
        chk("disp_secs", disp_secs, m_t[m_sel] % 60);
        chk("running", running, rv);
        chk("alarm", alarm, av);
    endtask

    task automatic cyc(input bit s, input bit ss, input bit p, input bit c, input bit r);
        sel = s; start_stop = ss; plus = p; clear = c; reset = r;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // kind: 0 sel, 1 start_stop, 2 plus, 3 clear
    task automatic press(input int kind);
        cyc(kind == 0, kind == 1, kind == 2, kind == 3, 1'b0);
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic timeout(input string tag);
        n_tests++;
        n_fail++;
        $error("FAIL %s: got timeout expected event", tag);
    endtask

    task automatic sync_to(input int cnt);
        int guard = 0;
        do begin
            cyc(0, 0, 0, 0, 0);
            guard++;
        end while (m_cnt != cnt && guard < 2 * DIV);
        if (m_cnt != cnt) timeout("sync");
    endtask

    task automatic run_ticks(input int n);
        int target = m_ticks + n;
        int guard  = 0;
        while (m_ticks < target && guard < DIV * n + DIV) begin
            cyc(0, 0, 0, 0, 0);
            guard++;
        end
        if (m_ticks < target) timeout("run_ticks");
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, "_h"}, disp_hours, h);
        chk({tag, "_m"}, disp_mins, m);
        chk({tag, "_s"}, disp_secs, s);
    endtask

    initial begin
        // Reset state
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
        chk_time("rst", 0, 0, 0);
        chk("rst_run", running, 0);
        chk("rst_alm", alarm, 0);
        chk("rst_sel", sel_idx, 0);

        // Two plus on ch0, start, count down to alarm and alarm expiry
        sync_to(0);
        press(2); press(2);
        chk_time("load2", 0, 2, 0);
        press(1);
        run_ticks(1);  chk_time("cd1", 0, 1, 59);
        run_ticks(60); chk_time("cd61", 0, 0, 59);
        run_ticks(59);
        chk("cd120_run", running[0], 0);
        chk("cd120_alm", alarm[0], 1);
        run_ticks(2);  chk("alm_hold", alarm[0], 1);
        run_ticks(1);  chk("alm_clr", alarm[0], 0);

        // Two channels running together, selection wrap
        press(3); press(2); press(1);
        press(0);
        press(2); press(2); press(1);
        chk("two_run", running, 4'b0011);
        run_ticks(1);
        press(0); press(0);
        chk("sel3", sel_idx, 3);
        press(0);
        chk("sel_wrap", sel_idx, 0);

        // Saturation on stopped ch2
        press(0); press(0);
        chk("sel2", sel_idx, 2);
        for (int i = 0; i < 1440; i++) press(2);
        chk_time("sat", 23, 59, 59);
        press(2);
        chk_time("sat_more", 23, 59, 59);
        press(3); press(2); press(1); press(2);
        chk("run_plus_run", running[2], 1);

        // Clear + start_stop coincident with a tick on running ch0
        press(0); press(0);
        press(3); press(2); press(1);
        sync_to(DIV - 1);
        cyc(0, 1, 0, 1, 0);
        chk_time("clr_ss", 0, 0, 0);
        chk("clr_ss_run", running[0], 0);
        cyc(0, 0, 0, 0, 0);

        // Start at zero ignored; start_stop during alarm clears it
        press(1);
        chk("start_zero", running[0], 0);
        press(2); press(1);
        run_ticks(60);
        chk("alm_set", alarm[0], 1);
        cyc(0, 1, 0, 0, 0);
        chk("ss_alm_clr", alarm[0], 0);
        chk("ss_alm_run", running[0], 0);
        cyc(0, 0, 0, 0, 0);

        // Reset mid-countdown with plus held high
        press(2); press(1);
        run_ticks(2);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 1);
            chk_time("rst_mid", 0, 0, 0);
            chk("rst_mid_run", running, 0);
            chk("rst_mid_alm", alarm, 0);
        end
        cyc(0, 0, 1, 0, 0);
        chk_time("rel_noinc", 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
        chk_time("pre_tick", 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk_time("first_tick", 0, 0, 59);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
